lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Data-memory access controller on the far side of the decoder's memory control signals (rw, whb, su).
- Accepts one load/store request per transaction over a valid/ready handshake and drives a word-organised data memory with byte enables.
- Waits for the memory acknowledge, then returns sign- or zero-extended load data, or a store completion, as a one-cycle response.
- Sits between the execute stage (ALU address, rs2 data) and the data RAM; its load result feeds the MemtoReg mux.

Parameters:
- ADDR_W, 32: byte-address width of `addr`. The memory-side word address is ADDR_W-2 bits.
- TIMEOUT_CYC, 255: maximum cycles spent in ACCESS without `mem_ack` before aborting. Legal range 1..255; the counter is 8 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- rw  in  1  1 = load (read), 0 = store (write)
- whb  in  2  access size: 10 = word, 01 = half, 00 = byte, 11 = illegal
- su  in  1  1 = sign-extend load, 0 = zero-extend load
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response strobe
- rdata  out  32  extended load data; 0 for stores and errors
- err  out  1  response is an error (misaligned, illegal size, or timeout); valid with rsp_valid
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_be  out  4  byte-lane enables
- mem_addr  out  ADDR_W-2  word address = addr[ADDR_W-1:2]
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read word, valid with mem_ack
- mem_ack  in  1  memory completion

Behaviour:
- One clock, `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values: state = IDLE, timeout counter = 0, rsp_valid = 0, rdata = 0, err = 0, mem_req = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.
- req_ready is combinational and equals (state == IDLE); it is therefore 1 immediately after reset.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - On req_valid & req_ready, latch rw, whb, su, addr, and wdata.
  - If the request is misaligned (half with addr[0] = 1, word with addr[1:0] != 0) or whb = 11: go to RESP with err = 1 and rdata = 0. No memory access occurs.
  - Otherwise go to ACCESS with the counter cleared.
- ACCESS:
  - Registered outputs: mem_req = 1, mem_we = ~rw, mem_be, mem_addr, and mem_wdata, all stable until exit.
  - Byte enables: byte access uses 4'b0001 << addr[1:0]; half uses 4'b0011 << {addr[1], 1'b0}; word uses 4'b1111.
  - mem_wdata: byte access replicates wdata[7:0] four times; half replicates wdata[15:0] twice; word passes wdata.
  - On mem_ack: select the lane from mem_rdata (byte lane addr[1:0], half lane addr[1]) and extend per su to form rdata (loads only; stores give rdata = 0). Set err = 0, go to RESP, and drop mem_req on the next edge.
  - If no ack, the counter increments each cycle. When the counter reaches TIMEOUT_CYC-1 without ack: go to RESP with err = 1 and rdata = 0, and drop mem_req.
  - An ack arriving in the same cycle as the timeout wins: a normal response is returned.
- RESP: rsp_valid = 1 for exactly one cycle, then return to IDLE. rdata and err hold their values until the next response.
- Latency, with the request accepted at edge T:
  - mem_req is asserted during T+1.
  - A zero-wait ack in T+1 gives rsp_valid in T+2.
  - A misaligned or illegal request gives rsp_valid in T+1.
  - The earliest next acceptance is T+3.
- mem_ack and mem_rdata are ignored outside ACCESS.
- req_valid is ignored while req_ready = 0. The requester must hold the request until it is accepted.
- Reset mid-transaction: mem_req and rsp_valid drop immediately, the state returns to IDLE, and no response is issued. The memory must tolerate an abandoned request.

Decomposition:
- Shared header/package lsu_defs holds:
  - WHB_WORD = 2'b10, WHB_HALF = 2'b01, WHB_BYTE = 2'b00
  - RW_LOAD = 1, RW_STORE = 0, SU_SIGNED = 1
  - state encodings IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2
  - These are also used by the decoder.
- One combinational sub-module, lsu_lane_align:
  - inputs: whb, su, addr[1:0], wdata, mem_rdata
  - outputs: mem_be, mem_wdata, extended load data, misalign flag
- The FSM and timeout counter stay in lsu_mem_ctrl.

Test Plan:
- LB signed, addr = 0x103, memory word 0x80FF_1234, ack after 2 waits -> mem_be = 0001b is not expected; lane 3 is selected, so mem_be = 1000b, mem_addr = 0x40, rdata = 0xFFFF_FF80, err = 0, rsp_valid pulses once 4 cycles after accept.
- LHU, addr = 0x202, word 0x8001_0000, zero-wait ack -> mem_be = 1100b, rdata = 0x0000_8001, rsp_valid at T+2.
- SB, addr = 0x005, wdata = 0xDEAD_BEA5, ack -> mem_we = 1, mem_be = 0010b, mem_wdata = 0xA5A5_A5A5, rdata = 0, err = 0.
- LW addr = 0x006, then SH addr = 0x001, then whb = 11 -> each gives err = 1, rsp_valid at T+1, mem_req never asserted.
- Load with mem_ack held 0, TIMEOUT_CYC = 4 -> mem_req high for exactly 4 cycles, then err = 1, rdata = 0, req_ready returns 1 one cycle later.
- rst_n pulsed low during ACCESS of an SW -> mem_req = 0 asynchronously, no rsp_valid. A new LW accepted after reset completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared load/store encodings and controller state type, also imported by the decoder.
package lsu_defs;

    localparam logic [1:0] WHB_WORD  = 2'b10;
    localparam logic [1:0] WHB_HALF  = 2'b01;
    localparam logic [1:0] WHB_BYTE  = 2'b00;

    localparam logic       RW_LOAD   = 1'b1;
    localparam logic       RW_STORE  = 1'b0;
    localparam logic       SU_SIGNED = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    function automatic logic whb_illegal(input logic [1:0] whb);
        return (whb == 2'b11);
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_align.sv
// Byte-lane steering: store-side enables/replication, load-side lane select and extension.
module lsu_lane_align
    import lsu_defs::*;
(
    input  logic [1:0]  whb,
    input  logic        su,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        mem_be    = 4'b0000;
        mem_wdata = wdata;
        ld_data   = 32'h0;
        misalign  = 1'b0;
        byte_lane = 8'(mem_rdata >> {addr_lo, 3'b000});
        half_lane = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (whb)
            WHB_BYTE: begin
                mem_be    = 4'b0001 << addr_lo;
                mem_wdata = {4{wdata[7:0]}};
                ld_data   = (su == SU_SIGNED) ? {{24{byte_lane[7]}}, byte_lane}
                                              : {24'h0, byte_lane};
            end
            WHB_HALF: begin
                mem_be    = 4'b0011 << {addr_lo[1], 1'b0};
                mem_wdata = {2{wdata[15:0]}};
                ld_data   = (su == SU_SIGNED) ? {{16{half_lane[15]}}, half_lane}
                                              : {16'h0, half_lane};
                misalign  = addr_lo[0];
            end
            WHB_WORD: begin
                mem_be    = 4'b1111;
                ld_data   = mem_rdata;
                misalign  = |addr_lo;
            end
            default: begin
                mem_be    = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory access controller: one request at a time, waits for mem_ack
// with a timeout, returns a one-cycle response with extended load data.
//
// state  | meaning
// IDLE   | ready for a request; bad requests go straight to RESP
// ACCESS | mem_req held, waiting for mem_ack or timeout
// RESP   | rsp_valid pulse, rdata/err valid
module lsu_mem_ctrl
    import lsu_defs::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              rw,
    input  logic [1:0]        whb,
    input  logic              su,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              rsp_valid,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    lsu_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [1:0]        whb_q, whb_d;
    logic              su_q, su_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              sel_idle;
    logic [1:0]        al_whb;
    logic              al_su;
    logic [1:0]        al_addr_lo;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic [31:0]       al_ld;
    logic              al_misalign;

    // One aligner serves both directions: live request fields in IDLE, latched ones in ACCESS.
    assign sel_idle   = (state_q == IDLE);
    assign al_whb     = sel_idle ? whb       : whb_q;
    assign al_su      = sel_idle ? su        : su_q;
    assign al_addr_lo = sel_idle ? addr[1:0] : addr_lo_q;

    lsu_lane_align u_align (
        .whb       (al_whb),
        .su        (al_su),
        .addr_lo   (al_addr_lo),
        .wdata     (wdata),
        .mem_rdata (mem_rdata),
        .mem_be    (al_be),
        .mem_wdata (al_wdata),
        .ld_data   (al_ld),
        .misalign  (al_misalign)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        whb_d       = whb_q;
        su_d        = su_q;
        addr_lo_d   = addr_lo_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rw_d      = rw;
                    whb_d     = whb;
                    su_d      = su;
                    addr_lo_d = addr[1:0];
                    if (al_misalign || whb_illegal(whb)) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        err_d       = 1'b1;
                        rdata_d     = 32'h0;
                    end else begin
                        state_d     = ACCESS;
                        cnt_d       = 8'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ~rw;
                        mem_be_d    = al_be;
                        mem_addr_d  = addr[ADDR_W-1:2];
                        mem_wdata_d = al_wdata;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack || (cnt_q == CNT_LAST)) begin
                    // ack beats a coincident timeout
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    err_d       = ~mem_ack;
                    rdata_d     = (mem_ack && rw_q == RW_LOAD) ? al_ld : 32'h0;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'b0000;
                    mem_addr_d  = '0;
                    mem_wdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            rw_q        <= 1'b0;
            whb_q       <= 2'b00;
            su_q        <= 1'b0;
            addr_lo_q   <= 2'b00;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            whb_q       <= whb_d;
            su_q        <= su_d;
            addr_lo_q   <= addr_lo_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl against a behavioural load/store reference model.
module tb_lsu_mem_ctrl;
    import lsu_defs::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        rw = 1'b0;
    logic [1:0]  whb = 2'b00;
    logic        su = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rw        (rw),
        .whb       (whb),
        .su        (su),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rdata     (rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [1:0] w_sz, input logic sgn,
                                             input logic [1:0] off, input logic [31:0] word);
        logic [31:0] v;
        v = word;
        if (w_sz == 2'b00) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (sgn && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (w_sz == 2'b01) begin
            v = (word >> (16 * off[1])) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_be(input logic [1:0] w_sz, input logic [1:0] off);
        logic [31:0] o;
        o = 32'(off);
        if (w_sz == 2'b00) return 32'd1 << o;
        if (w_sz == 2'b01) return 32'd3 << (o & 32'd2);
        return 32'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] w_sz, input logic [31:0] d);
        if (w_sz == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
        if (w_sz == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic ref_bad(input logic [1:0] w_sz, input logic [1:0] off);
        return (w_sz == 2'b11) || (w_sz == 2'b01 && off[0]) || (w_sz == 2'b10 && off != 2'b00);
    endfunction

    // Caller is positioned 1ns after a rising edge with the DUT idle.
    task automatic run_txn(input logic t_rw, input logic [1:0] t_whb, input logic t_su,
                           input logic [31:0] t_addr, input logic [31:0] t_wdata,
                           input logic [31:0] t_word, input int waits, input string nm);
        logic        bad, e_err, e_we;
        logic [31:0] e_rdata;
        int          exp_lat, exp_req, n_req, rsp_at, gap;

        bad     = ref_bad(t_whb, t_addr[1:0]);
        e_err   = bad || (waits >= TO);
        e_rdata = (e_err || t_rw == RW_STORE) ? 32'h0 : ref_load(t_whb, t_su, t_addr[1:0], t_word);
        e_we    = ~t_rw;
        exp_lat = bad ? 1 : ((waits < TO) ? waits + 2 : TO + 1);
        exp_req = bad ? 0 : ((waits < TO) ? waits + 1 : TO);

        chk({nm, "_ready_idle"}, {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1;
        rw = t_rw; whb = t_whb; su = t_su; addr = t_addr; wdata = t_wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rw = 1'($urandom); whb = 2'($urandom); su = 1'($urandom);
        addr = $urandom; wdata = $urandom;

        n_req  = 0;
        rsp_at = -1;
        for (int c = 1; c <= 40; c++) begin
            if (rsp_at > 0) begin
                chk({nm, "_rsp_one_cycle"}, {31'h0, rsp_valid}, 32'd0);
                chk({nm, "_ready_after"}, {31'h0, req_ready}, 32'd1);
                break;
            end
            if (mem_req) begin
                n_req++;
                chk({nm, "_we"}, {31'h0, mem_we}, {31'h0, e_we});
                chk({nm, "_be"}, {28'h0, mem_be}, ref_be(t_whb, t_addr[1:0]));
                chk({nm, "_maddr"}, {2'b00, mem_addr}, t_addr >> 2);
                chk({nm, "_mwdata"}, mem_wdata, ref_wdata(t_whb, t_wdata));
            end
            if (rsp_valid) begin
                rsp_at = c;
                chk({nm, "_lat"}, c, exp_lat);
                chk({nm, "_err"}, {31'h0, err}, {31'h0, e_err});
                chk({nm, "_rdata"}, rdata, e_rdata);
                chk({nm, "_ready_resp"}, {31'h0, req_ready}, 32'd0);
            end
            mem_ack   = !bad && (c - 1 == waits);
            mem_rdata = mem_ack ? t_word : $urandom;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        if (rsp_at < 0) chk({nm, "_no_rsp"}, 32'd0, 32'd1);
        chk({nm, "_req_cycles"}, n_req, exp_req);

        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
        chk({nm, "_rdata_hold"}, rdata, e_rdata);
        chk({nm, "_err_hold"}, {31'h0, err}, {31'h0, e_err});
    endtask

    initial begin
        #2;
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'd0);
        chk("rst_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'h0, err}, 32'd0);
        chk("rst_be", {28'h0, mem_be}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(RW_LOAD, WHB_BYTE, SU_SIGNED, 32'h103, 32'h0, 32'h80FF_1234, 2, "lb_signed");
        run_txn(RW_LOAD, WHB_HALF, 1'b0, 32'h202, 32'h0, 32'h8001_0000, 0, "lhu");
        run_txn(RW_STORE, WHB_BYTE, 1'b0, 32'h005, 32'hDEAD_BEA5, 32'h1234_5678, 1, "sb");
        run_txn(RW_LOAD, WHB_WORD, 1'b0, 32'h006, 32'h0, 32'h1111_2222, 0, "lw_mis");
        run_txn(RW_STORE, WHB_HALF, 1'b0, 32'h001, 32'hCAFE, 32'h0, 0, "sh_mis");
        run_txn(RW_LOAD, 2'b11, 1'b0, 32'h010, 32'h0, 32'h0, 0, "illegal");
        run_txn(RW_LOAD, WHB_WORD, 1'b0, 32'h020, 32'h0, 32'h5555_AAAA, 99, "timeout");
        run_txn(RW_LOAD, WHB_HALF, SU_SIGNED, 32'h032, 32'h0, 32'hF00D_0123, 3, "ack_at_limit");

        // Abandoned store: reset while in ACCESS
        req_valid = 1'b1; rw = RW_STORE; whb = WHB_WORD; su = 1'b0;
        addr = 32'h40; wdata = 32'h1234_ABCD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstmid_req_before", {31'h0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_req", {31'h0, mem_req}, 32'd0);
        chk("rstmid_rsp", {31'h0, rsp_valid}, 32'd0);
        chk("rstmid_ready", {31'h0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("rstmid_no_rsp", {31'h0, rsp_valid}, 32'd0);
        end
        run_txn(RW_LOAD, WHB_WORD, 1'b0, 32'h100, 32'h0, 32'h0BAD_F00D, 0, "lw_after_rst");

        for (int i = 0; i < 150; i++) begin
            run_txn(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                    32'($urandom_range(0, 4095)), $urandom, $urandom,
                    int'($urandom_range(0, 5)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
